// File: rtl/alu_pkg.sv
// Shared types and widths for the round-robin ALU arbiter and its bench.
package alu_pkg;
    localparam int ALU_W = 2;
    localparam int RES_W = 4;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_MUL = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    // Next round-robin start position after serving requester g out of n.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Per-requester request/response handshake bundle for alu_arbiter.
interface alu_arbiter_if import alu_pkg::*; #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0][ALU_W-1:0] req_a;
    logic [N_REQ-1:0][ALU_W-1:0] req_b;
    logic [N_REQ-1:0][ALU_W-1:0] req_op;
    logic [N_REQ-1:0]            rsp_valid;
    logic [N_REQ-1:0]            rsp_ready;
    logic [RES_W-1:0]            rsp_result;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/alu_rr_pick.sv
// Combinational round-robin search: first set valid bit at or above ptr_i, with wrap.
module alu_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             found_o
);
    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr_i) + k) % N_REQ);
            if (valid_i[idx]) begin
                grant_o = idx;
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external 2-bit ALU between N_REQ requesters, one op in flight at a time.
module alu_arbiter import alu_pkg::*; #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [ALU_W-1:0] alu_op,
    input  logic [RES_W-1:0] alu_result,
    output logic             busy
);
    localparam int               IDX_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] gnt_q;
    logic [ALU_W-1:0] a_q;
    logic [ALU_W-1:0] b_q;
    alu_op_e          op_q;
    logic [RES_W-1:0] result_q;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    alu_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_idx),
        .found_o (pick_found)
    );

    // Handshakes are masked during reset so nothing is accepted or delivered.
    assign bus.req_ready  = (!rst && state_q == IDLE && pick_found) ? (ONE << pick_idx) : '0;
    assign bus.rsp_valid  = (!rst && state_q == RESP) ? (ONE << gnt_q) : '0;
    assign bus.rsp_result = result_q;
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_op         = op_q;
    assign busy           = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        a_q     <= bus.req_a[pick_idx];
                        b_q     <= bus.req_b[pick_idx];
                        op_q    <= alu_op_e'(bus.req_op[pick_idx]);
                        gnt_q   <= pick_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_result;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[gnt_q]) begin
                        ptr_q   <= IDX_W'(rr_next(int'(gnt_q), N_REQ));
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
